// File: rtl/div_check_pkg.sv
// Shared definitions for the divisibility checker: FSM state encoding and
// the remainder-width helper used by both the RTL and its testbench.
package div_check_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bits needed to hold any remainder modulo divisor (0 .. divisor-1).
  function automatic int unsigned rem_width(input int unsigned divisor);
    return $clog2(divisor);
  endfunction

endpackage

// File: rtl/mod_step.sv
// One restoring-division step: next_rem = (2*rem + in_bit) mod DIVISOR,
// valid whenever rem < DIVISOR.
//   rem      : current partial remainder
//   in_bit   : next operand bit, MSB first
//   next_rem : updated partial remainder
module mod_step
  import div_check_pkg::*;
#(
  parameter  int unsigned DIVISOR = 3,
  localparam int unsigned RW      = rem_width(DIVISOR)
) (
  input  logic [RW-1:0] rem,
  input  logic          in_bit,
  output logic [RW-1:0] next_rem
);

  // One extra bit because 2*rem + 1 can reach 2*DIVISOR - 1.
  logic [RW:0] t_c;

  always_comb begin
    t_c = {rem, in_bit};
    if (t_c >= (RW+1)'(DIVISOR)) begin
      next_rem = RW'(t_c - (RW+1)'(DIVISOR));
    end else begin
      next_rem = RW'(t_c);
    end
  end

endmodule

// File: rtl/divisibility_checker.sv
// Handshaked classifier: computes in_data mod DIVISOR bit-serially (MSB first,
// one bit per cycle), reports remainder / divisible / even, and keeps
// saturating counts of consumed and divisible results.
//   clk, rst                      : clock, synchronous active-high reset
//   in_valid/in_ready/in_data     : operand stream
//   out_valid/out_ready           : result handshake
//   out_data/out_rem/out_divisible/out_even : registered result fields
//   clr_counts                    : synchronous clear of both counters
//   total_count/div_count         : saturating statistics
module divisibility_checker
  import div_check_pkg::*;
#(
  parameter  int unsigned WIDTH   = 8,
  parameter  int unsigned DIVISOR = 3,
  parameter  int unsigned CNT_W   = 16,
  localparam int unsigned RW      = rem_width(DIVISOR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [RW-1:0]    out_rem,
  output logic             out_divisible,
  output logic             out_even,
  input  logic             clr_counts,
  output logic [CNT_W-1:0] total_count,
  output logic [CNT_W-1:0] div_count
);

  localparam int unsigned      IW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   op_q, op_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [RW-1:0]      rem_q, rem_d;
  logic [RW-1:0]      step_rem_c;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [RW-1:0]      out_rem_q, out_rem_d;
  logic               out_div_q, out_div_d;
  logic               out_even_q, out_even_d;
  logic [CNT_W-1:0]   total_q, total_d;
  logic [CNT_W-1:0]   divc_q, divc_d;
  logic               out_hs_c;

  // Single restoring step on the currently indexed operand bit.
  mod_step #(.DIVISOR(DIVISOR)) u_step (
    .rem      (rem_q),
    .in_bit   (op_q[idx_q]),
    .next_rem (step_rem_c)
  );

  assign out_hs_c = out_valid_q && out_ready;

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    idx_d      = idx_q;
    rem_d      = rem_q;
    out_data_d = out_data_q;
    out_rem_d  = out_rem_q;
    out_div_d  = out_div_q;
    out_even_d = out_even_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = in_data;
          rem_d   = '0;
          idx_d   = IW'(WIDTH - 1);
          state_d = CALC;
        end
      end
      CALC: begin
        rem_d = step_rem_c;
        idx_d = idx_q - IW'(1);
        // Result fields only change here, on the last bit.
        if (idx_q == '0) begin
          state_d    = DONE;
          out_data_d = op_q;
          out_rem_d  = step_rem_c;
          out_div_d  = (step_rem_c == '0);
          out_even_d = !op_q[0];
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // Saturating statistics; clear takes priority over a coincident handshake.
  always_comb begin
    total_d = total_q;
    divc_d  = divc_q;
    if (clr_counts) begin
      total_d = '0;
      divc_d  = '0;
    end else if (out_hs_c) begin
      if (total_q != CNT_MAX) begin
        total_d = total_q + CNT_W'(1);
      end
      if (out_div_q && (divc_q != CNT_MAX)) begin
        divc_d = divc_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      idx_q       <= '0;
      rem_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_rem_q   <= '0;
      out_div_q   <= 1'b0;
      out_even_q  <= 1'b0;
      total_q     <= '0;
      divc_q      <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      idx_q       <= idx_d;
      rem_q       <= rem_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_rem_q   <= out_rem_d;
      out_div_q   <= out_div_d;
      out_even_q  <= out_even_d;
      total_q     <= total_d;
      divc_q      <= divc_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_rem       = out_rem_q;
  assign out_divisible = out_div_q;
  assign out_even      = out_even_q;
  assign total_count   = total_q;
  assign div_count     = divc_q;

endmodule

// File: tb/tb_divisibility_checker.sv
// Bench for divisibility_checker: an 8-bit/mod-3 instance (16-bit counters)
// and a lockstep twin with 2-bit counters share one stream; a 4-bit/mod-2
// instance and a mod-5 mod_step are checked separately.
module tb_divisibility_checker;
  import div_check_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 3;
  localparam int unsigned RA = rem_width(D);
  localparam int unsigned RM = rem_width(5);

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] rem;
    logic       div;
    logic       even;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Stream A: dut_a (CNT_W 16) and dut_c (CNT_W 2) in lockstep
  logic          a_in_valid, a_out_ready;
  logic [7:0]    a_in_data;
  logic          a_in_ready, a_out_valid, a_out_div, a_out_even;
  logic [7:0]    a_out_data;
  logic [RA-1:0] a_out_rem;
  logic [15:0]   a_total, a_divc;
  logic          clr_a, clr_c;
  logic          c_in_ready, c_out_valid, c_out_div, c_out_even;
  logic [7:0]    c_out_data;
  logic [RA-1:0] c_out_rem;
  logic [1:0]    c_total, c_divc;

  // Stream B: WIDTH 4, DIVISOR 2
  logic          b_in_valid, b_out_ready, b_in_ready, b_out_valid;
  logic [3:0]    b_in_data, b_out_data;
  logic [0:0]    b_out_rem;
  logic          b_out_div, b_out_even, clr_b;
  logic [15:0]   b_total, b_divc;

  logic [RM-1:0] ms_rem, ms_next;
  logic          ms_bit;

  int   tests = 0;
  int   fails = 0;
  int   tot_a = 0, div_a = 0, tot_c = 0, div_c = 0;
  exp_t qa[$];
  exp_t qb[$];

  divisibility_checker #(.WIDTH(W), .DIVISOR(D), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_rem(a_out_rem), .out_divisible(a_out_div),
    .out_even(a_out_even), .clr_counts(clr_a), .total_count(a_total),
    .div_count(a_divc));

  divisibility_checker #(.WIDTH(W), .DIVISOR(D), .CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(c_in_ready),
    .in_data(a_in_data), .out_valid(c_out_valid), .out_ready(a_out_ready),
    .out_data(c_out_data), .out_rem(c_out_rem), .out_divisible(c_out_div),
    .out_even(c_out_even), .clr_counts(clr_c), .total_count(c_total),
    .div_count(c_divc));

  divisibility_checker #(.WIDTH(4), .DIVISOR(2), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_rem(b_out_rem), .out_divisible(b_out_div),
    .out_even(b_out_even), .clr_counts(clr_b), .total_count(b_total),
    .div_count(b_divc));

  mod_step #(.DIVISOR(5)) u_ms (.rem(ms_rem), .in_bit(ms_bit), .next_rem(ms_next));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  // One operand through stream A; hold = cycles of backpressure with
  // in_valid asserted; clr = pulse clr_counts on dut_c at the handshake edge.
  task automatic do_op_a(input logic [7:0] d, input int hold, input logic clr);
    exp_t e;
    int   lat;
    e.data = d;
    e.rem  = 8'(int'(d) % int'(D));
    e.div  = (e.rem == 8'd0);
    e.even = !d[0];
    qa.push_back(e);
    @(negedge clk);
    check("a_in_ready_idle", 32'(a_in_ready), 32'd1);
    a_in_valid = 1'b1;
    a_in_data  = d;
    @(negedge clk);
    a_in_valid = 1'b0;
    a_in_data  = 8'd0;
    lat = 0;
    while (!a_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("a_latency", 32'(lat), 32'(W));
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", 32'(a_out_valid), 32'd1);
      check("hold_in_ready", 32'(a_in_ready), 32'd0);
      check("hold_data", 32'(a_out_data), 32'(qa[0].data));
      check("hold_rem", 32'(a_out_rem), 32'(qa[0].rem));
      a_in_valid = 1'b1;
      a_in_data  = 8'(i + 100);
      @(negedge clk);
    end
    a_in_valid = 1'b0;
    e = qa.pop_front();
    check("a_data", 32'(a_out_data), 32'(e.data));
    check("a_rem", 32'(a_out_rem), 32'(e.rem));
    check("a_div", 32'(a_out_div), 32'(e.div));
    check("a_even", 32'(a_out_even), 32'(e.even));
    check("c_valid", 32'(c_out_valid), 32'd1);
    check("c_in_ready", 32'(c_in_ready), 32'd0);
    check("c_data", 32'(c_out_data), 32'(e.data));
    check("c_rem", 32'(c_out_rem), 32'(e.rem));
    check("c_div", 32'(c_out_div), 32'(e.div));
    check("c_even", 32'(c_out_even), 32'(e.even));
    a_out_ready = 1'b1;
    clr_c       = clr;
    @(negedge clk);
    a_out_ready = 1'b0;
    clr_c       = 1'b0;
    tot_a++;
    if (e.div) div_a++;
    if (clr) begin
      tot_c = 0;
      div_c = 0;
    end else begin
      if (tot_c < 3) tot_c++;
      if (e.div && div_c < 3) div_c++;
    end
    check("a_total", 32'(a_total), 32'(tot_a));
    check("a_divc", 32'(a_divc), 32'(div_a));
    check("c_total", 32'(c_total), 32'(tot_c));
    check("c_divc", 32'(c_divc), 32'(div_c));
    check("a_valid_after_hs", 32'(a_out_valid), 32'd0);
    check("a_ready_after_hs", 32'(a_in_ready), 32'd1);
  endtask

  task automatic do_op_b(input logic [3:0] d);
    exp_t e;
    int   lat;
    e.data = 8'(d);
    e.rem  = 8'(d[0]);
    e.div  = !d[0];
    e.even = !d[0];
    qb.push_back(e);
    @(negedge clk);
    b_in_valid = 1'b1;
    b_in_data  = d;
    @(negedge clk);
    b_in_valid = 1'b0;
    lat = 0;
    while (!b_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("b_latency", 32'(lat), 32'd4);
    e = qb.pop_front();
    check("b_data", 32'(b_out_data), 32'(e.data));
    check("b_rem", 32'(b_out_rem), 32'(e.rem));
    check("b_div", 32'(b_out_div), 32'(e.div));
    check("b_even", 32'(b_out_even), 32'(e.even));
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int  seen;
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = 8'd0; a_out_ready = 1'b0;
    clr_a = 1'b0; clr_c = 1'b0;
    b_in_valid = 1'b0; b_in_data = 4'd0; b_out_ready = 1'b0; clr_b = 1'b0;
    ms_rem = '0; ms_bit = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_in_ready", 32'(a_in_ready), 32'd1);
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_out_data", 32'(a_out_data), 32'd0);
    check("rst_out_rem", 32'(a_out_rem), 32'd0);
    check("rst_out_div", 32'(a_out_div), 32'd0);
    check("rst_out_even", 32'(a_out_even), 32'd0);
    check("rst_total", 32'(a_total), 32'd0);
    check("rst_divc", 32'(a_divc), 32'd0);
    check("rst_b_in_ready", 32'(b_in_ready), 32'd1);
    rst = 1'b0;

    // Exhaustive restoring step, modulus 5
    for (int r = 0; r < 5; r++) begin
      for (int b = 0; b < 2; b++) begin
        ms_rem = RM'(r);
        ms_bit = b[0];
        #1;
        check("mod_step5", 32'(ms_next), 32'((2 * r + b) % 5));
      end
    end

    // Basic classification and boundaries
    do_op_a(8'd9, 0, 1'b0);
    do_op_a(8'd255, 0, 1'b0);
    do_op_a(8'd254, 0, 1'b0);
    do_op_a(8'd0, 0, 1'b0);

    // Backpressure with ignored in_valid
    do_op_a(8'd7, 5, 1'b0);

    // Multiples of 3: 2-bit counters saturate, then clear wins at 6th
    do_op_a(8'd3, 0, 1'b0);
    do_op_a(8'd6, 0, 1'b0);
    do_op_a(8'd12, 0, 1'b0);
    do_op_a(8'd15, 0, 1'b0);
    do_op_a(8'd18, 0, 1'b0);
    do_op_a(8'd21, 0, 1'b1);
    do_op_a(8'd100, 2, 1'b0);

    // DIVISOR 2, WIDTH 4 sweep
    for (int v = 0; v < 16; v++) do_op_b(4'(v));
    check("b_total", 32'(b_total), 32'd16);
    check("b_divc", 32'(b_divc), 32'd8);

    // Reset three cycles into CALC abandons the operation
    @(negedge clk);
    a_in_valid = 1'b1;
    a_in_data  = 8'd6;
    @(negedge clk);
    a_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tot_a = 0; div_a = 0; tot_c = 0; div_c = 0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (a_out_valid) seen = 1;
      @(negedge clk);
    end
    check("abort_no_valid", 32'(seen), 32'd0);
    check("abort_total", 32'(a_total), 32'd0);
    check("abort_divc", 32'(a_divc), 32'd0);
    do_op_a(8'd10, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
